rice_core_id_stage: RTL and testbench

Instruction-decode stage; directly downstream of the fetch stage. Consumes fetched (pc, inst) words, decodes RV32I, and reads operands from an internal register file that has a write-back port. Registers the decoded bundle for the execute stage. Back-pressures fetch on downstream stall or load-use hazard; drops in-flight work on flush.

---
 rtl/rice_core_pkg.sv | 174 +++++++++++++++++
 rtl/rice_core_id_stage_if.sv | 33 +++
 rtl/rice_core_register_file.sv | 34 +++
 rtl/rice_core_id_stage.sv | 83 ++++++++
 tb/tb_rice_core_id_stage.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/rice_core_pkg.sv
// Shared RV32I decode types, opcode constants and the instruction decode function.
// Build option: RICE_CORE_RV32M_EN enables decoding of the RV32M multiply/divide ops.
package rice_core_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [5:0] {
        OP_NOP = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ECALL, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } rice_core_op_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_t;

    typedef struct packed {
        rice_core_op_t   op;
        logic [4:0]      rd;
        logic            uses_rs1;
        logic            uses_rs2;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } decode_t;

    function automatic logic is_load(input rice_core_op_t op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic decode_t rice_core_decode(input logic [31:0] inst);
        decode_t    d;
        imm_fmt_t   fmt;
        logic [2:0] f3;
        logic [6:0] f7;
        f3  = inst[14:12];
        f7  = inst[31:25];
        d   = '0;
        fmt = IMM_NONE;
        d.rd = inst[11:7];
        case (inst[6:0])
            OPC_LUI:   begin d.op = OP_LUI;   fmt = IMM_U; end
            OPC_AUIPC: begin d.op = OP_AUIPC; fmt = IMM_U; end
            OPC_JAL:   begin d.op = OP_JAL;   fmt = IMM_J; end
            OPC_JALR: begin
                d.op = OP_JALR; fmt = IMM_I; d.uses_rs1 = 1'b1;
                if (f3 != 3'b000) d.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                fmt = IMM_B; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.rd = '0;
                case (f3)
                    3'b000:  d.op = OP_BEQ;
                    3'b001:  d.op = OP_BNE;
                    3'b100:  d.op = OP_BLT;
                    3'b101:  d.op = OP_BGE;
                    3'b110:  d.op = OP_BLTU;
                    3'b111:  d.op = OP_BGEU;
                    default: d.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                fmt = IMM_I; d.uses_rs1 = 1'b1;
                case (f3)
                    3'b000:  d.op = OP_LB;
                    3'b001:  d.op = OP_LH;
                    3'b010:  d.op = OP_LW;
                    3'b100:  d.op = OP_LBU;
                    3'b101:  d.op = OP_LHU;
                    default: d.illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                fmt = IMM_S; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.rd = '0;
                case (f3)
                    3'b000:  d.op = OP_SB;
                    3'b001:  d.op = OP_SH;
                    3'b010:  d.op = OP_SW;
                    default: d.illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                fmt = IMM_I; d.uses_rs1 = 1'b1;
                case (f3)
                    3'b000: d.op = OP_ADDI;
                    3'b010: d.op = OP_SLTI;
                    3'b011: d.op = OP_SLTIU;
                    3'b100: d.op = OP_XORI;
                    3'b110: d.op = OP_ORI;
                    3'b111: d.op = OP_ANDI;
                    3'b001: if (f7 == 7'b0000000) d.op = OP_SLLI; else d.illegal = 1'b1;
                    default: begin
                        if (f7 == 7'b0000000)      d.op = OP_SRLI;
                        else if (f7 == 7'b0100000) d.op = OP_SRAI;
                        else                       d.illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  d.op = OP_ADD;
                        3'b001:  d.op = OP_SLL;
                        3'b010:  d.op = OP_SLT;
                        3'b011:  d.op = OP_SLTU;
                        3'b100:  d.op = OP_XOR;
                        3'b101:  d.op = OP_SRL;
                        3'b110:  d.op = OP_OR;
                        default: d.op = OP_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d.op = OP_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d.op = OP_SRA;
`ifdef RICE_CORE_RV32M_EN
                end else if (f7 == 7'b0000001) begin
                    case (f3)
                        3'b000:  d.op = OP_MUL;
                        3'b001:  d.op = OP_MULH;
                        3'b010:  d.op = OP_MULHSU;
                        3'b011:  d.op = OP_MULHU;
                        3'b100:  d.op = OP_DIV;
                        3'b101:  d.op = OP_DIVU;
                        3'b110:  d.op = OP_REM;
                        default: d.op = OP_REMU;
                    endcase
`endif
                end else begin
                    d.illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin d.op = OP_NOP; d.rd = '0; end
            OPC_SYSTEM: begin
                d.rd = '0;
                if (inst[31:7] == 25'h0000000)      d.op = OP_ECALL;
                else if (inst[31:7] == 25'h0002000) d.op = OP_EBREAK;
                else                                d.illegal = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) d.illegal = 1'b1;
        // Illegal words still travel as a valid bundle, but must not write or read registers.
        if (d.illegal) begin
            d.op = OP_NOP; d.rd = '0; d.uses_rs1 = 1'b0; d.uses_rs2 = 1'b0; fmt = IMM_NONE;
        end
        case (fmt)
            IMM_I:   d.imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   d.imm = {inst[31:12], 12'h000};
            IMM_J:   d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: d.imm = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rice_core_id_stage_if.sv
// Fetch, write-back, pipeline control and decoded-bundle signals of the decode stage.
interface rice_core_id_stage_if
    import rice_core_pkg::*;
();
    logic            enable;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_inst;
    logic            if_stall;
    logic            flush;
    logic            stall;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_value;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    rice_core_op_t   id_op;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_rs1_value;
    logic [XLEN-1:0] id_rs2_value;
    logic [XLEN-1:0] id_imm;
    logic            id_illegal;

    modport master (
        output enable, if_valid, if_pc, if_inst, flush, stall, wb_valid, wb_rd, wb_value,
        input  if_stall, id_valid, id_pc, id_op, id_rd, id_rs1_value, id_rs2_value, id_imm, id_illegal
    );

    modport slave (
        input  enable, if_valid, if_pc, if_inst, flush, stall, wb_valid, wb_rd, wb_value,
        output if_stall, id_valid, id_pc, id_op, id_rd, id_rs1_value, id_rs2_value, id_imm, id_illegal
    );
endinterface

// File: rtl/rice_core_register_file.sv
// 31 x XLEN integer register file: x0 reads zero, two write-first read ports, one write port.
module rice_core_register_file #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [4:0]      rd_addr_a,
    output logic [XLEN-1:0] rd_data_a,
    input  logic [4:0]      rd_addr_b,
    output logic [XLEN-1:0] rd_data_b
);
    logic [XLEN-1:0] regs [1:31];
    logic            wr_live;

    assign wr_live = wr_en && (wr_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < 32; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (rd_addr_a != 5'd0) rd_data_a = (wr_live && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
        if (rd_addr_b != 5'd0) rd_data_b = (wr_live && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
    end
endmodule

// File: rtl/rice_core_id_stage.sv
// RV32I decode stage: decode, operand read, load-use interlock, registered bundle to execute.
// Build option: RICE_CORE_RV32M_EN enables decoding of the RV32M multiply/divide ops.
module rice_core_id_stage
    import rice_core_pkg::*;
#(
    parameter int unsigned          XLEN       = 32,
    parameter logic [XLEN-1:0]      INITIAL_PC = 32'h8000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rice_core_id_stage_if.slave  bus
);
    decode_t         dec;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rs1_value, rs2_value;
    logic            hazard, accept;

    logic            valid_q, illegal_q;
    logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
    rice_core_op_t   op_q;
    logic [4:0]      rd_q;

    assign dec = rice_core_decode(bus.if_inst);
    assign rs1 = bus.if_inst[19:15];
    assign rs2 = bus.if_inst[24:20];

    rice_core_register_file #(.XLEN(XLEN)) u_regs (
        .clk       (i_clk),
        .rst       (i_rst),
        .wr_en     (bus.wb_valid),
        .wr_addr   (bus.wb_rd),
        .wr_data   (bus.wb_value),
        .rd_addr_a (rs1),
        .rd_data_a (rs1_value),
        .rd_addr_b (rs2),
        .rd_data_b (rs2_value)
    );

    // Only a load currently sitting in the bundle can create a load-use hazard.
    assign hazard = bus.if_valid && valid_q && is_load(op_q) && (rd_q != 5'd0)
                 && ((dec.uses_rs1 && rs1 == rd_q) || (dec.uses_rs2 && rs2 == rd_q));
    assign accept = bus.if_valid && !bus.stall && !hazard && !bus.flush && bus.enable;
    assign bus.if_stall = bus.if_valid && !accept && !bus.flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q   <= 1'b0;
            pc_q      <= INITIAL_PC;
            op_q      <= OP_NOP;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else if (!bus.enable || bus.flush) begin
            valid_q <= 1'b0;
        end else if (bus.stall) begin
            valid_q <= valid_q;
        end else if (hazard) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                pc_q      <= bus.if_pc;
                op_q      <= dec.op;
                rd_q      <= dec.rd;
                rs1_q     <= rs1_value;
                rs2_q     <= rs2_value;
                imm_q     <= dec.imm;
                illegal_q <= dec.illegal;
            end
        end
    end

    assign bus.id_valid     = valid_q;
    assign bus.id_pc        = pc_q;
    assign bus.id_op        = op_q;
    assign bus.id_rd        = rd_q;
    assign bus.id_rs1_value = rs1_q;
    assign bus.id_rs2_value = rs2_q;
    assign bus.id_imm       = imm_q;
    assign bus.id_illegal   = illegal_q;
endmodule

// File: tb/tb_rice_core_id_stage.sv
// Scoreboard bench for rice_core_id_stage: expected bundles queued at drive time, popped after each edge.
module tb_rice_core_id_stage;
    import rice_core_pkg::*;

    typedef struct {
        logic          valid;
        logic          full;
        logic [31:0]   pc;
        rice_core_op_t op;
        logic [4:0]    rd;
        logic [31:0]   rs1;
        logic [31:0]   rs2;
        logic [31:0]   imm;
        logic          ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t last;

    rice_core_id_stage_if bus();

    rice_core_id_stage #(.XLEN(32), .INITIAL_PC(32'h8000_0000)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic valid, input logic [31:0] pc, input rice_core_op_t op,
                        input logic [4:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic ill);
        last = '{valid, 1'b1, pc, op, rd, rs1, rs2, imm, ill};
        sb.push_back(last);
    endtask

    task automatic push_hold();
        sb.push_back(last);
    endtask

    task automatic push_bubble();
        last.valid = 1'b0;
        sb.push_back('{1'b0, 1'b0, last.pc, last.op, last.rd, last.rs1, last.rs2, last.imm, last.ill});
    endtask

    task automatic stall_is(input string tag, input logic exp);
        #1;
        check(tag, 32'(bus.if_stall), 32'(exp));
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("valid", 32'(bus.id_valid), 32'(e.valid));
            if (e.full) begin
                check("pc",      bus.id_pc,           e.pc);
                check("op",      32'(bus.id_op),      32'(e.op));
                check("rd",      32'(bus.id_rd),      32'(e.rd));
                check("rs1",     bus.id_rs1_value,    e.rs1);
                check("rs2",     bus.id_rs2_value,    e.rs2);
                check("imm",     bus.id_imm,          e.imm);
                check("illegal", 32'(bus.id_illegal), 32'(e.ill));
            end
        end
        bus.wb_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        bus.if_valid = 1'b1;
        bus.if_pc    = pc;
        bus.if_inst  = inst;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] value);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_value = value;
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b1; bus.flush = 1'b0; bus.stall = 1'b0;
        bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_inst = '0;
        bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_value = '0;

        push(1'b0, 32'h8000_0000, OP_NOP, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;

        fetch(32'h8000_0000, 32'h0050_0093);                          // addi x1,x0,5
        stall_is("addi_stall", 1'b0);
        push(1'b1, 32'h8000_0000, OP_ADDI, 5'd1, 32'h0, 32'h0, 32'd5, 1'b0);
        tick();

        fetch(32'h8000_0004, 32'h0021_01B3);                          // add x3,x2,x2 with wb bypass
        wb(5'd2, 32'hDEAD_BEEF);
        push(1'b1, 32'h8000_0004, OP_ADD, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        tick();

        fetch(32'h8000_0008, 32'h0020_0233);                          // add x4,x0,x2 with wb to x0
        wb(5'd0, 32'h1234_5678);
        push(1'b1, 32'h8000_0008, OP_ADD, 5'd4, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0);
        tick();

        fetch(32'h8000_000C, 32'h0000_A283);                          // lw x5,0(x1)
        push(1'b1, 32'h8000_000C, OP_LW, 5'd5, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();

        fetch(32'h8000_0010, 32'h0002_8333);                          // add x6,x5,x0 -> load-use
        wb(5'd5, 32'h0000_0055);
        stall_is("hazard_stall", 1'b1);
        push_bubble();
        tick();
        stall_is("hazard_clear", 1'b0);
        push(1'b1, 32'h8000_0010, OP_ADD, 5'd6, 32'h0000_0055, 32'h0, 32'h0, 1'b0);
        tick();

        fetch(32'h8000_0014, 32'h0000_A003);                          // lw x0,0(x1)
        push(1'b1, 32'h8000_0014, OP_LW, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        fetch(32'h8000_0018, 32'h0000_03B3);                          // add x7,x0,x0: no hazard
        stall_is("x0_load_no_stall", 1'b0);
        push(1'b1, 32'h8000_0018, OP_ADD, 5'd7, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();

        fetch(32'h8000_001C, 32'hFFF0_0413);                          // addi x8,x0,-1 under stall
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stall_is("stall_hold", 1'b1);
            push_hold();
            tick();
        end
        bus.stall = 1'b0;
        stall_is("stall_release", 1'b0);
        push(1'b1, 32'h8000_001C, OP_ADDI, 5'd8, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        tick();

        fetch(32'h8000_0020, 32'h0000_0013);
        bus.stall = 1'b1;
        stall_is("stall_pre_flush", 1'b1);
        push_hold();
        tick();
        bus.flush = 1'b1;
        stall_is("flush_no_stall", 1'b0);
        push_bubble();
        tick();
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        fetch(32'h8000_0100, 32'hFFFF_FFFF);
        push(1'b1, 32'h8000_0100, OP_NOP, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        fetch(32'h8000_0104, 32'h0000_0000);
        push(1'b1, 32'h8000_0104, OP_NOP, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();

        fetch(32'h8000_0108, 32'h0231_00B3);                          // mul x1,x2,x3
`ifdef RICE_CORE_RV32M_EN
        push(1'b1, 32'h8000_0108, OP_MUL, 5'd1, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0);
`else
        push(1'b1, 32'h8000_0108, OP_NOP, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1);
`endif
        tick();

        fetch(32'h8000_010C, 32'hFE20_AE23);                          // sw x2,-4(x1)
        push(1'b1, 32'h8000_010C, OP_SW, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 1'b0);
        tick();

        bus.enable = 1'b0;
        stall_is("disable_stall", 1'b1);
        push_bubble();
        tick();

        bus.enable = 1'b1;
        bus.flush  = 1'b1;
        rst        = 1'b1;
        push(1'b0, 32'h8000_0000, OP_NOP, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
